// File: rtl/axis_pkt_demux.sv
// Packet-granular AXI-stream demultiplexer: routes each packet to the sink chosen by
// its first-beat destination through a single output register; out-of-range packets are dropped.
module axis_pkt_demux #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DEST_W    = 3,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_W-1:0]    s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    input  logic [DEST_W-1:0]    s_dest,
    output logic                 s_ready,
    output logic [DATA_W-1:0]    m_data,
    output logic [NUM_PORTS-1:0] m_valid,
    output logic                 m_last,
    input  logic [NUM_PORTS-1:0] m_ready,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic                 busy
);
    localparam int unsigned DEST_XW = DEST_W + 1;

    typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

    state_t               state, state_d;
    logic [DEST_W-1:0]    sel, sel_d;
    logic [DEST_W-1:0]    route_c;
    logic                 route_ok_c;
    logic [NUM_PORTS-1:0] route_oh_c;
    logic                 buf_valid_c;
    logic                 drain_c;
    logic                 accept_c;
    logic                 load_c;
    logic                 drop_inc_c;

    // m_valid is kept one-hot, so it doubles as the output-register occupancy and port
    assign buf_valid_c = |m_valid;
    assign drain_c     = |(m_valid & m_ready);
    assign s_ready     = !route_ok_c || !buf_valid_c || drain_c;
    assign accept_c    = s_valid && s_ready;
    assign load_c      = accept_c && route_ok_c;
    assign busy        = (state != IDLE) || buf_valid_c;

    // Route selection: first beat uses s_dest, later beats use the latched sel
    always_comb begin
        route_c    = sel;
        route_ok_c = 1'b0;
        route_oh_c = '0;
        case (state)
            IDLE: begin
                route_c    = s_dest;
                route_ok_c = ({1'b0, s_dest} < DEST_XW'(NUM_PORTS));
            end
            PKT:     route_ok_c = 1'b1;
            default: route_ok_c = 1'b0;
        endcase
        for (int i = 0; i < NUM_PORTS; i++) begin
            route_oh_c[i] = (route_c == DEST_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            state <= state_d;
            sel   <= sel_d;
        end
    end

    always_comb begin
        state_d    = state;
        sel_d      = sel;
        drop_inc_c = 1'b0;
        if (accept_c) begin
            case (state)
                IDLE: begin
                    if (route_ok_c) begin
                        if (!s_last) begin
                            state_d = PKT;
                            sel_d   = s_dest;
                        end
                    end else if (!s_last) begin
                        state_d = DROP;
                    end else begin
                        drop_inc_c = 1'b1;
                    end
                end
                PKT: begin
                    if (s_last) state_d = IDLE;
                end
                DROP: begin
                    if (s_last) begin
                        state_d    = IDLE;
                        drop_inc_c = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output register: a new load may replace a beat draining in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= '0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (load_c) begin
            m_valid <= route_oh_c;
            m_data  <= s_data;
            m_last  <= s_last;
        end else if (drain_c) begin
            m_valid <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop_inc_c && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end
endmodule
